rc4_ctrl: RTL and testbench

//  RC4 sequencer sitting directly upstream of the 3-port S-box RAM. It drives every RAM port.

---
 rtl/rc4_pkg.sv | 17 +
 rtl/rc4_key_sel.sv | 36 +++
 rtl/rc4_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rc4_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 sequencer: FSM state encoding and S-box size.
package rc4_pkg;

  localparam int SBOX_SIZE = 256;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA_RD,
    KSA_SW,
    PRGA_RD,
    PRGA_SW,
    PRGA_T,
    OUT
  } state_t;

endpackage

// File: rtl/rc4_key_sel.sv
// Key latch plus wrapping byte counter k; presents key byte k to the KSA.
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             key_byte
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  logic [7:0]    key_q [KEY_BYTES];
  logic [KW-1:0] k;

  // k wraps by compare, so non-power-of-two key lengths need no modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
      for (int n = 0; n < KEY_BYTES; n++) key_q[n] <= '0;
    end else if (load) begin
      k <= '0;
      for (int n = 0; n < KEY_BYTES; n++) key_q[n] <= key[8*n +: 8];
    end else if (step) begin
      k <= (k == K_LAST) ? '0 : k + 1'b1;
    end
  end

  assign key_byte = key_q[k];

endmodule

// File: rtl/rc4_ctrl.sv
// RC4 sequencer driving a 3-port S-box RAM: init -> KSA -> PRGA keystream.
// Optional keystream drop after KSA is enabled with RC4_DROP_EN.
module rc4_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16,
  parameter int DROP_N    = 768
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic                   busy,
  output logic                   ksa_done,
  output logic                   ks_valid,
  output logic [7:0]             ks_data,
  input  logic                   ks_ready,
  output logic                   ram_rst_n,
  output logic                   ram_wen,
  output logic [7:0]             ram_raddr_1,
  output logic [7:0]             ram_waddr_2,
  output logic [7:0]             ram_addr_3,
  output logic [7:0]             ram_wdata_2,
  output logic [7:0]             ram_wdata_3,
  input  logic [7:0]             ram_rdata_1,
  input  logic [7:0]             ram_rdata_3,
  output state_t                 fsm_state
);

  localparam logic [7:0] I_LAST = 8'(SBOX_SIZE - 1);

  if (DROP_N < 0 || DROP_N > 1023) begin : g_drop_range
    $error("rc4_ctrl: DROP_N must fit the 10-bit drop counter");
  end

  state_t     state, state_n;
  logic [7:0] i, j, t, si;
  logic [7:0] key_byte;
  logic       start_go;
  logic       drop_active;
  logic       drop_last;
  logic       ksa_end_done;

  assign start_go  = (state == IDLE) && start && !stop;
  assign fsm_state = state;

  rc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk      (clk),
    .rst      (rst),
    .load     (start_go),
    .step     ((state == KSA_SW) && !stop),
    .key      (key),
    .key_byte (key_byte)
  );

`ifdef RC4_DROP_EN
  localparam logic [9:0] DROP_CNT = 10'(DROP_N);
  logic [9:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            drop_cnt <= '0;
    else if (start_go)                                  drop_cnt <= '0;
    else if (!stop && state == PRGA_T && drop_active)   drop_cnt <= drop_cnt + 10'd1;
  end

  assign drop_active  = (drop_cnt != DROP_CNT);
  assign drop_last    = drop_active && (drop_cnt == DROP_CNT - 10'd1);
  assign ksa_end_done = (DROP_CNT == 10'd0);
`else
  assign drop_active  = 1'b0;
  assign drop_last    = 1'b0;
  assign ksa_end_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Keystream handshake: ks_data is held stable while ks_valid && !ks_ready;
  // a byte transfers on a rising edge with ks_valid && ks_ready (and no stop).
  always_comb begin
    state_n     = state;
    busy        = (state != IDLE);
    ram_wen     = 1'b0;
    ram_raddr_1 = i;
    if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_n = INIT;
        INIT:    state_n = KSA_RD;
        KSA_RD:  state_n = KSA_SW;
        KSA_SW:  state_n = (i == I_LAST) ? PRGA_RD : KSA_RD;
        PRGA_RD: state_n = PRGA_SW;
        PRGA_SW: state_n = PRGA_T;
        PRGA_T:  state_n = drop_active ? PRGA_RD : OUT;
        OUT:     if (ks_ready) state_n = PRGA_RD;
        default: state_n = IDLE;
      endcase
    end
    if (state == KSA_SW || state == PRGA_SW) ram_wen = 1'b1;
    if (state == PRGA_T) ram_raddr_1 = t;
  end

  // Swap: port 2 writes S[j] into S[i], port 3 writes saved S[i] into S[j].
  assign ram_addr_3  = j;
  assign ram_waddr_2 = i;
  assign ram_wdata_2 = ram_rdata_3;
  assign ram_wdata_3 = si;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i         <= '0;
      j         <= '0;
      t         <= '0;
      si        <= '0;
      ks_valid  <= 1'b0;
      ks_data   <= '0;
      ksa_done  <= 1'b0;
      ram_rst_n <= 1'b0;
    end else begin
      ram_rst_n <= !start_go;
      if (stop) begin
        ks_valid <= 1'b0;
        ksa_done <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            i        <= '0;
            j        <= '0;
            ksa_done <= 1'b0;
          end
          KSA_RD: begin
            j  <= j + ram_rdata_1 + key_byte;
            si <= ram_rdata_1;
          end
          KSA_SW: begin
            if (i == I_LAST) begin
              i <= 8'd1;
              j <= '0;
              if (ksa_end_done) ksa_done <= 1'b1;
            end else begin
              i <= i + 8'd1;
            end
          end
          PRGA_RD: begin
            si <= ram_rdata_1;
            j  <= j + ram_rdata_1;
          end
          PRGA_SW: t <= si + ram_rdata_3;
          PRGA_T: begin
            if (drop_active) begin
              i <= i + 8'd1;
              if (drop_last) ksa_done <= 1'b1;
            end else begin
              ks_data  <= ram_rdata_1;
              ks_valid <= 1'b1;
            end
          end
          OUT: if (ks_ready) begin
            ks_valid <= 1'b0;
            i        <= i + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_ctrl.sv
// Bench for rc4_ctrl: two instances ("Key" with 3 key bytes, "Wiki" with 4),
// each with a behavioural S-box RAM, checked against a software RC4 model.
module tb_rc4_ctrl;
  import rc4_pkg::*;

`ifdef RC4_DROP_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 0;
`endif
  localparam int FIRST_EDGE = 516 + 3 * DROP;
  localparam int NGEN = 40;
  localparam logic [23:0] KEY_A = 24'h79654B;   // "Key", byte 0 = 'K'
  localparam logic [31:0] KEY_B = 32'h696B6957; // "Wiki", byte 0 = 'W'

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 0, stop_a = 0, ready_a = 1;
  logic start_b = 0, stop_b = 0, ready_b = 1;
  logic busy_a, done_a, valid_a, rrst_a, wen_a;
  logic busy_b, done_b, valid_b, rrst_b, wen_b;
  logic [7:0] data_a, raddr1_a, waddr2_a, addr3_a, wdata2_a, wdata3_a, rdata1_a, rdata3_a;
  logic [7:0] data_b, raddr1_b, waddr2_b, addr3_b, wdata2_b, wdata3_b, rdata1_b, rdata3_b;
  state_t state_a, state_b;

  rc4_ctrl #(.KEY_BYTES(3), .DROP_N(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .key(KEY_A),
    .busy(busy_a), .ksa_done(done_a), .ks_valid(valid_a), .ks_data(data_a),
    .ks_ready(ready_a), .ram_rst_n(rrst_a), .ram_wen(wen_a),
    .ram_raddr_1(raddr1_a), .ram_waddr_2(waddr2_a), .ram_addr_3(addr3_a),
    .ram_wdata_2(wdata2_a), .ram_wdata_3(wdata3_a),
    .ram_rdata_1(rdata1_a), .ram_rdata_3(rdata3_a), .fsm_state(state_a)
  );

  rc4_ctrl #(.KEY_BYTES(4), .DROP_N(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .key(KEY_B),
    .busy(busy_b), .ksa_done(done_b), .ks_valid(valid_b), .ks_data(data_b),
    .ks_ready(ready_b), .ram_rst_n(rrst_b), .ram_wen(wen_b),
    .ram_raddr_1(raddr1_b), .ram_waddr_2(waddr2_b), .ram_addr_3(addr3_b),
    .ram_wdata_2(wdata2_b), .ram_wdata_3(wdata3_b),
    .ram_rdata_1(rdata1_b), .ram_rdata_3(rdata3_b), .fsm_state(state_b)
  );

  // S-box RAMs: synchronous identity init, two write ports, combinational reads.
  logic [7:0] s_a [256];
  logic [7:0] s_b [256];
  always @(posedge clk) begin
    if (!rrst_a) for (int n = 0; n < 256; n++) s_a[n] <= 8'(n);
    else if (wen_a) begin
      s_a[waddr2_a] <= wdata2_a;
      s_a[addr3_a]  <= wdata3_a;
    end
    if (!rrst_b) for (int n = 0; n < 256; n++) s_b[n] <= 8'(n);
    else if (wen_b) begin
      s_b[waddr2_b] <= wdata2_b;
      s_b[addr3_b]  <= wdata3_b;
    end
  end
  assign rdata1_a = s_a[raddr1_a];
  assign rdata3_a = s_a[addr3_a];
  assign rdata1_b = s_b[raddr1_b];
  assign rdata3_b = s_b[addr3_b];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Software RC4: textbook KSA then PRGA, discarding the first drop bytes.
  logic [7:0] gen_buf [64];
  task automatic gen_stream(input int klen, input logic [31:0] kvec, input int drop, input int n);
    int s [256];
    int i, j, tmp, kb;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kb = int'(kvec[8*(x % klen) +: 8]);
      j = (j + s[x] + kb) % 256;
      tmp = s[x]; s[x] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int c = 0; c < drop + n; c++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      if (c >= drop) gen_buf[c - drop] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  logic [7:0] exp_q_a [$];
  logic [7:0] exp_q_b [$];

  task automatic load_exp_a();
    gen_stream(3, {8'h00, KEY_A}, DROP, NGEN);
    exp_q_a.delete();
    for (int c = 0; c < NGEN; c++) exp_q_a.push_back(gen_buf[c]);
  endtask

  task automatic load_exp_b();
    gen_stream(4, KEY_B, DROP, NGEN);
    exp_q_b.delete();
    for (int c = 0; c < NGEN; c++) exp_q_b.push_back(gen_buf[c]);
  endtask

  // Compare process: accepted bytes vs model, stall stability, no RAM write while presenting.
  int got_a = 0, got_b = 0;
  logic stall_a = 0, stall_b = 0;
  logic [7:0] held_a = 0, held_b = 0;
  always @(negedge clk) begin
    if (stall_a) begin
      check("stall_valid_a", valid_a, 1);
      check("stall_data_a", data_a, held_a);
    end
    if (stall_b) begin
      check("stall_valid_b", valid_b, 1);
      check("stall_data_b", data_b, held_b);
    end
    if (valid_a) check("wen_during_out_a", wen_a, 0);
    if (valid_b) check("wen_during_out_b", wen_b, 0);
    if (valid_a && ready_a && !stop_a && !rst) begin
      if (exp_q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_byte_a: actual %0h required none", data_a);
      end else check("ks_data_a", data_a, exp_q_a.pop_front());
      got_a <= got_a + 1;
    end
    if (valid_b && ready_b && !stop_b && !rst) begin
      if (exp_q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_byte_b: actual %0h required none", data_b);
      end else check("ks_data_b", data_b, exp_q_b.pop_front());
      got_b <= got_b + 1;
    end
    stall_a <= valid_a && !ready_a && !stop_a && !rst;
    stall_b <= valid_b && !ready_b && !stop_b && !rst;
    held_a  <= data_a;
    held_b  <= data_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic a, input logic b);
    start_a = a;
    start_b = b;
    tick();
    start_a = 0;
    start_b = 0;
  endtask

  task automatic wait_bytes(input int na, input int nb);
    int n = 0;
    while ((got_a < na || got_b < nb) && n < 3000) begin
      tick();
      n++;
    end
    check("byte_wait_in_budget", (got_a >= na && got_b >= nb), 1);
  endtask

  task automatic stop_all();
    stop_a = 1;
    stop_b = 1;
    tick();
    stop_a = 0;
    stop_b = 0;
    check("stopped_busy_a", busy_a, 0);
    check("stopped_busy_b", busy_b, 0);
  endtask

  logic [7:0] lit_key  [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] lit_wiki [6]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
  logic [7:0] lit_drop [4]  = '{8'hB7, 8'h34, 8'hCA, 8'h72};

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_a, first_b, base_a, base_b, nstall, n;

    // Pin the model to published vectors.
    gen_stream(3, {8'h00, KEY_A}, 0, 10);
    for (int c = 0; c < 10; c++) check("model_key", gen_buf[c], lit_key[c]);
    gen_stream(4, KEY_B, 0, 6);
    for (int c = 0; c < 6; c++) check("model_wiki", gen_buf[c], lit_wiki[c]);
    gen_stream(3, {8'h00, KEY_A}, 4, 4);
    for (int c = 0; c < 4; c++) check("model_key_drop4", gen_buf[c], lit_drop[c]);

    // Reset values.
    repeat (3) tick();
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_wen_a", wen_a, 0);
    check("rst_ram_rst_n_a", rrst_a, 0);
    check("rst_state_a", state_a, IDLE);
    check("rst_busy_b", busy_b, 0);
    check("rst_valid_b", valid_b, 0);
    rst = 0;
    tick();
    check("idle_ram_rst_n_a", rrst_a, 1);

    // Streams for both keys, first-valid latency, stop during a pending handshake.
    load_exp_a();
    load_exp_b();
    base_a = got_a;
    base_b = got_b;
    pulse_start(1, 1);
    check("init_ram_rst_n_a", rrst_a, 0);
    check("init_busy_a", busy_a, 1);
    first_a = -1;
    first_b = -1;
    for (int e = 1; e <= 2000 && (first_a < 0 || first_b < 0); e++) begin
      tick();
      if (valid_a && first_a < 0) first_a = e;
      if (valid_b && first_b < 0) first_b = e;
    end
    check("first_valid_edge_a", first_a, FIRST_EDGE);
    check("first_valid_edge_b", first_b, FIRST_EDGE);
    check("ksa_done_at_first_b", done_b, 1);
    wait_bytes(base_a + 10, base_b + 6);
    n = 0;
    while (!valid_b && n < 10) begin
      tick();
      n++;
    end
    check("valid_before_stop_b", valid_b, 1);
    stop_all();
    check("stop_clears_valid_b", valid_b, 0);
    check("stop_clears_done_b", done_b, 0);
    check("stop_wen_b", wen_b, 0);

    // Backpressure: hold ks_ready low 10 cycles on byte 2.
    load_exp_a();
    base_a = got_a;
    nstall = 0;
    pulse_start(1, 0);
    n = 0;
    while (got_a - base_a < 10 && n < 3000) begin
      tick();
      n++;
      if (valid_a && got_a - base_a == 2 && nstall < 10) begin
        ready_a = 0;
        nstall++;
      end else ready_a = 1;
    end
    ready_a = 1;
    check("stall_cycles_a", nstall, 10);
    check("stall_run_in_budget", (got_a - base_a >= 10), 1);
    stop_all();

    // Abort at KSA cycle 100 (start+stop together), then restart with a stray start.
    load_exp_a();
    pulse_start(1, 0);
    repeat (100) tick();
    check("mid_ksa_busy_a", busy_a, 1);
    check("mid_ksa_done_a", done_a, 0);
    stop_a = 1;
    start_a = 1;
    tick();
    check("abort_busy_a", busy_a, 0);
    check("abort_wen_a", wen_a, 0);
    tick();
    check("start_stop_idle_a", busy_a, 0);
    check("start_stop_no_init_a", rrst_a, 1);
    stop_a = 0;
    start_a = 0;
    load_exp_a();
    base_a = got_a;
    pulse_start(1, 0);
    first_a = -1;
    for (int e = 1; e <= 2000 && first_a < 0; e++) begin
      tick();
      start_a = (e == 50);
      if (valid_a) first_a = e;
    end
    start_a = 0;
    check("restart_first_valid_a", first_a, FIRST_EDGE);
    wait_bytes(base_a + 10, got_b);
    stop_all();

    // Asynchronous reset mid-PRGA, then a clean restart.
    load_exp_a();
    base_a = got_a;
    pulse_start(1, 0);
    wait_bytes(base_a + 3, got_b);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("arst_busy_a", busy_a, 0);
    check("arst_valid_a", valid_a, 0);
    check("arst_data_a", data_a, 0);
    check("arst_wen_a", wen_a, 0);
    check("arst_done_a", done_a, 0);
    check("arst_ram_rst_n_a", rrst_a, 0);
    check("arst_state_a", state_a, IDLE);
    repeat (2) tick();
    rst = 0;
    tick();
    load_exp_a();
    base_a = got_a;
    pulse_start(1, 0);
    wait_bytes(base_a + 10, got_b);
    stop_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
